// File: rtl/tu_trigger_tx_if.sv
//------------------------------------------------------------------------------
// Module : tu_trigger_tx_if
// Brief  : Payload valid/ready handshake between a word source and tu_trigger_tx.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface tu_trigger_tx_if;
    logic [63:0] payload_data;
    logic        payload_valid;
    logic        payload_ready;

    modport master (
        output payload_data,
        output payload_valid,
        input  payload_ready
    );

    modport slave (
        input  payload_data,
        input  payload_valid,
        output payload_ready
    );
endinterface

`default_nettype wire

// File: rtl/tu_trigger_tx.sv
//------------------------------------------------------------------------------
// Module : tu_trigger_tx
// Brief  : Trigger-unit transmitter: training burst then payload, lane-transposed
//          and optionally bit-rotated per lane for an 8x8 serializer.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tu_trigger_tx #(
    parameter logic [63:0] TRAIN_WORD = 64'hF0E1_D2C3_B4A5_9687,
    parameter logic [63:0] IDLE_WORD  = 64'h0000_0000_0000_0000,
    parameter logic [15:0] TRAIN_LEN  = 16'd64
) (
    input  wire logic        S_AXI_ACLK,
    input  wire logic        S_AXI_ARESETN,
    input  wire logic        tx_ena,
    input  wire logic [2:0]  slip_offset,
    tu_trigger_tx_if.slave   pay,
    output logic [63:0]      tx_word,
    output logic             tx_training,
    output logic             tx_busy,
    output logic [31:0]      word_cnt
);

    typedef enum logic [3:0] {
        S_IDLE  = 4'b0001,
        S_TRAIN = 4'b0010,
        S_RUN   = 4'b0100,
        S_DRAIN = 4'b1000
    } state_t;

    state_t       r_state;
    logic         r_ena_p;
    logic [2:0]   r_slip;
    logic [15:0]  r_train_cnt;
    logic         r_drain;
    logic [31:0]  r_word_cnt;
    logic [63:0]  r_sel;
    logic         r_tr_p;
    logic [63:0]  r_prev;
    logic [63:0]  r_tx_word;
    logic         r_tx_training;

    logic         w_start;
    logic         w_ready;
    logic         w_accept;
    logic [63:0]  w_t;
    logic [15:0]  w_cat [8];
    logic [63:0]  w_rot;

    assign w_start  = tx_ena & ~r_ena_p;
    assign w_ready  = (r_state == S_RUN) & tx_ena;
    assign w_accept = w_ready & pay.payload_valid;

    // Undo the receiver's transposition: lane l, bit i carries logical bit 8i+7-l.
    always_comb begin
        w_t = '0;
        for (int l = 0; l < 8; l++) begin
            for (int i = 0; i < 8; i++) begin
                w_t[8*l+i] = r_sel[8*i+7-l];
            end
        end
    end

    // Each lane is taken from its current and previous byte, shifted by the latched slip.
    always_comb begin
        w_rot = '0;
        for (int l = 0; l < 8; l++) begin
            w_cat[l] = {w_t[8*l +: 8], r_prev[8*l +: 8]};
            w_rot[8*l +: 8] = w_cat[l][15 - int'(r_slip) -: 8];
        end
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_state       <= S_IDLE;
            r_ena_p       <= 1'b0;
            r_slip        <= 3'd0;
            r_train_cnt   <= 16'd0;
            r_drain       <= 1'b0;
            r_word_cnt    <= 32'd0;
            r_sel         <= 64'd0;
            r_tr_p        <= 1'b0;
            r_prev        <= 64'd0;
            r_tx_word     <= 64'd0;
            r_tx_training <= 1'b0;
        end else begin
            r_ena_p       <= tx_ena;
            r_tr_p        <= (r_state == S_TRAIN);
            r_prev        <= w_t;
            r_tx_word     <= w_rot;
            r_tx_training <= r_tr_p;

            case (r_state)
                S_IDLE: begin
                    r_sel <= IDLE_WORD;
                    if (w_start) begin
                        r_slip      <= slip_offset;
                        r_train_cnt <= 16'd0;
                        r_word_cnt  <= 32'd0;
                        r_state     <= S_TRAIN;
                    end
                end
                S_TRAIN: begin
                    r_sel       <= TRAIN_WORD;
                    r_train_cnt <= r_train_cnt + 16'd1;
                    if (!tx_ena) begin
                        r_drain <= 1'b0;
                        r_state <= S_DRAIN;
                    end else if (r_train_cnt == TRAIN_LEN - 16'd1) begin
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (w_accept) begin
                        r_sel <= pay.payload_data;
                        if (r_word_cnt != 32'hFFFF_FFFF) begin
                            r_word_cnt <= r_word_cnt + 32'd1;
                        end
                    end else begin
                        r_sel <= IDLE_WORD;
                    end
                    if (!tx_ena) begin
                        r_drain <= 1'b0;
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    r_sel   <= IDLE_WORD;
                    r_drain <= 1'b1;
                    if (r_drain) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_sel   <= IDLE_WORD;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign pay.payload_ready = w_ready;
    assign tx_word           = r_tx_word;
    assign tx_training       = r_tx_training;
    assign tx_busy           = (r_state != S_IDLE);
    assign word_cnt          = r_word_cnt;

endmodule

`default_nettype wire

// File: tb/tb_tu_trigger_tx.sv
//------------------------------------------------------------------------------
// Module : tb_tu_trigger_tx
// Brief  : Self-checking bench for tu_trigger_tx (directed table + random vs model).
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_tu_trigger_tx;

    localparam logic [63:0] TW = 64'hF0E1_D2C3_B4A5_9687;
    localparam logic [63:0] IW = 64'h0000_0000_0000_0000;
    localparam int          TL = 4;

    logic        clk;
    logic        rst_n;
    logic        tx_ena;
    logic [2:0]  slip_offset;
    logic [63:0] tx_word;
    logic        tx_training;
    logic        tx_busy;
    logic [31:0] word_cnt;

    int n_vec;
    int n_miss;

    tu_trigger_tx_if pif ();

    tu_trigger_tx #(
        .TRAIN_WORD (TW),
        .IDLE_WORD  (IW),
        .TRAIN_LEN  (16'(TL))
    ) dut (
        .S_AXI_ACLK    (clk),
        .S_AXI_ARESETN (rst_n),
        .tx_ena        (tx_ena),
        .slip_offset   (slip_offset),
        .pay           (pif.slave),
        .tx_word       (tx_word),
        .tx_training   (tx_training),
        .tx_busy       (tx_busy),
        .word_cnt      (word_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Spec-level mappings: logical word <-> serializer lanes.
    function automatic logic [63:0] tmap(input logic [63:0] w);
        logic [63:0] r;
        r = '0;
        for (int l = 0; l < 8; l++)
            for (int i = 0; i < 8; i++)
                r[8*l+i] = w[8*i+7-l];
        return r;
    endfunction

    function automatic logic [63:0] rx_unmap(input logic [63:0] t);
        logic [63:0] r;
        r = '0;
        for (int l = 0; l < 8; l++)
            for (int i = 0; i < 8; i++)
                r[8*i+7-l] = t[8*l+i];
        return r;
    endfunction

    function automatic logic [63:0] rot(input logic [63:0] t, input logic [63:0] p, input int k);
        logic [63:0] r;
        logic [15:0] c;
        r = '0;
        for (int l = 0; l < 8; l++) begin
            c = {t[8*l +: 8], p[8*l +: 8]};
            c = c >> (8 - k);
            r[8*l +: 8] = c[7:0];
        end
        return r;
    endfunction

    function automatic logic [63:0] rol_lanes(input logic [63:0] w, input int j);
        logic [63:0] r;
        logic [15:0] b;
        r = '0;
        for (int l = 0; l < 8; l++) begin
            b = {8'd0, w[8*l +: 8]} << j;
            r[8*l +: 8] = b[7:0] | b[15:8];
        end
        return r;
    endfunction

    // Reference model: phase + remaining-cycle counters, 2-stage word history.
    int          m_ph;      // 0 idle, 1 train, 2 run, 3 drain
    int          m_left;
    int          m_slip;
    logic        m_enap;
    logic [31:0] m_cnt;
    logic [63:0] m_sel;
    logic        m_trp;
    logic [63:0] m_prevt;
    logic [63:0] m_tx;
    logic        m_trn;

    task automatic model_reset();
        m_ph = 0; m_left = 0; m_slip = 0; m_enap = 1'b0; m_cnt = 32'd0;
        m_sel = 64'd0; m_trp = 1'b0; m_prevt = 64'd0; m_tx = 64'd0; m_trn = 1'b0;
    endtask

    task automatic model_step(input logic ena, input logic [2:0] slip, input logic valid,
                              input logic [63:0] data);
        logic        start;
        logic [63:0] t;
        start   = ena && !m_enap;
        t       = tmap(m_sel);
        m_tx    = rot(t, m_prevt, m_slip);
        m_trn   = m_trp;
        m_prevt = t;
        m_trp   = (m_ph == 1);
        case (m_ph)
            0: begin
                m_sel = IW;
                if (start) begin
                    m_slip = int'(slip); m_cnt = 32'd0; m_left = TL; m_ph = 1;
                end
            end
            1: begin
                m_sel = TW;
                if (!ena) begin
                    m_ph = 3; m_left = 2;
                end else begin
                    m_left = m_left - 1;
                    if (m_left == 0) m_ph = 2;
                end
            end
            2: begin
                if (!ena) begin
                    m_sel = IW; m_ph = 3; m_left = 2;
                end else if (valid) begin
                    m_sel = data;
                    if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
                end else begin
                    m_sel = IW;
                end
            end
            default: begin
                m_sel = IW;
                m_left = m_left - 1;
                if (m_left == 0) m_ph = 0;
            end
        endcase
        m_enap = ena;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // Called at negedge+1: drive, compare against the model, advance the model, move to next negedge+1.
    task automatic step(input logic ena, input logic [2:0] slip, input logic valid,
                        input logic [63:0] data);
        tx_ena = ena; slip_offset = slip;
        pif.payload_valid = valid; pif.payload_data = data;
        #1;
        chk("payload_ready", 64'(pif.payload_ready), 64'((m_ph == 2) && ena));
        chk("tx_word", tx_word, m_tx);
        chk("tx_training", 64'(tx_training), 64'(m_trn));
        chk("tx_busy", 64'(tx_busy), 64'(m_ph != 0));
        chk("word_cnt", 64'(word_cnt), 64'(m_cnt));
        model_step(ena, slip, valid, data);
        @(negedge clk);
        #1;
    endtask

    typedef struct {
        logic [63:0] payload;
        logic [63:0] exp_tx;
    } vec_t;

    vec_t tbl [6];

    initial begin
        int n_train;
        logic [63:0] ttw;

        tbl[0] = '{64'h0102_0304_0506_0708, 64'hAA66_1E01_0000_0000};
        tbl[1] = '{64'h0000_0000_0000_0000, 64'h0000_0000_0000_0000};
        tbl[2] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF};
        tbl[3] = '{64'h8080_8080_8080_8080, 64'h0000_0000_0000_00FF};
        tbl[4] = '{64'h0000_0000_0000_00FF, 64'h0101_0101_0101_0101};
        tbl[5] = '{64'hFF00_0000_0000_0000, 64'h8080_8080_8080_8080};

        n_vec = 0; n_miss = 0;
        rst_n = 1'b0; tx_ena = 1'b0; slip_offset = 3'd0;
        pif.payload_valid = 1'b0; pif.payload_data = 64'd0;
        model_reset();
        repeat (3) @(negedge clk);
        #1;
        chk("reset tx_word", tx_word, 64'd0);
        chk("reset tx_busy", 64'(tx_busy), 64'd0);
        chk("reset word_cnt", 64'(word_cnt), 64'd0);
        rst_n = 1'b1;

        // Start at slip 0: exactly TL training words carrying the transposed TRAIN_WORD.
        step(1'b0, 3'd0, 1'b0, 64'd0);
        step(1'b1, 3'd0, 1'b0, 64'd0);
        chk("busy after start", 64'(tx_busy), 64'd1);
        n_train = 0;
        for (int c = 0; c < 10; c++) begin
            if (tx_training) begin
                n_train++;
                chk("train word", tx_word, tmap(TW));
            end
            step(1'b1, 3'd0, 1'b0, 64'd0);
        end
        chk("train count", 64'(n_train), 64'(TL));

        // Payload table: one accepted word each, appears two cycles later.
        for (int v = 0; v < 6; v++) begin
            step(1'b1, 3'd0, 1'b1, tbl[v].payload);
            step(1'b1, 3'd0, 1'b0, 64'd0);
            chk("table tx_word", tx_word, tbl[v].exp_tx);
            chk("table recover", rx_unmap(tx_word), tbl[v].payload);
            chk("table word_cnt", 64'(word_cnt), 64'(v + 1));
        end

        // Drop enable while valid is held: nothing more counted, two drain cycles.
        step(1'b1, 3'd0, 1'b1, 64'h1111_2222_3333_4444);
        step(1'b0, 3'd0, 1'b1, 64'h5555_6666_7777_8888);
        chk("drain no count", 64'(word_cnt), 64'd7);
        chk("drain busy0", 64'(tx_busy), 64'd1);
        step(1'b0, 3'd0, 1'b1, 64'h5555_6666_7777_8888);
        chk("drain busy1", 64'(tx_busy), 64'd1);
        step(1'b0, 3'd0, 1'b0, 64'd0);
        chk("drain idle", 64'(tx_busy), 64'd0);
        repeat (2) step(1'b0, 3'd0, 1'b0, 64'd0);

        // Slip 3: lanes rotated; five receiver bitslips recover TRAIN_WORD. Later slip changes ignored.
        step(1'b1, 3'd3, 1'b0, 64'd0);
        for (int c = 0; c < 3; c++) step(1'b1, 3'($urandom_range(7)), 1'b0, 64'd0);
        ttw = tmap(TW);
        chk("slip3 word", tx_word, rol_lanes(ttw, 3));
        chk("slip3 unaligned", 64'(rx_unmap(tx_word) == TW), 64'd0);
        chk("slip3 recover", rx_unmap(rol_lanes(tx_word, 5)), TW);
        repeat (4) step(1'b1, 3'($urandom_range(7)), 1'b0, 64'd0);
        repeat (4) step(1'b0, 3'd0, 1'b0, 64'd0);

        // Enable drops on the last training cycle: DRAIN, never RUN; restart pulse in DRAIN ignored.
        step(1'b1, 3'd0, 1'b0, 64'd0);
        repeat (TL - 1) step(1'b1, 3'd0, 1'b0, 64'd0);
        step(1'b0, 3'd0, 1'b1, 64'd9);
        step(1'b1, 3'd0, 1'b1, 64'd9);
        chk("drain wins busy", 64'(tx_busy), 64'd1);
        step(1'b1, 3'd0, 1'b1, 64'd9);
        chk("no restart from drain", 64'(tx_busy), 64'd0);
        repeat (3) step(1'b1, 3'd0, 1'b1, 64'd9);
        chk("held enable idle", 64'(tx_busy), 64'd0);
        step(1'b0, 3'd0, 1'b0, 64'd0);

        // Asynchronous reset in the middle of training.
        step(1'b1, 3'd2, 1'b0, 64'd0);
        repeat (3) step(1'b1, 3'd2, 1'b0, 64'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async rst tx_word", tx_word, 64'd0);
        chk("async rst training", 64'(tx_training), 64'd0);
        chk("async rst busy", 64'(tx_busy), 64'd0);
        chk("async rst word_cnt", 64'(word_cnt), 64'd0);
        model_reset();
        tx_ena = 1'b0;
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        step(1'b0, 3'd0, 1'b0, 64'd0);

        // Randomized traffic against the model.
        begin
            logic ena_r;
            ena_r = 1'b0;
            for (int c = 0; c < 2000; c++) begin
                if ($urandom_range(24) == 0) ena_r = ~ena_r;
                step(ena_r, 3'($urandom_range(7)), 1'($urandom_range(1)),
                     {$urandom, $urandom});
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

`default_nettype wire
